// File: rtl/param_memory.sv
// Single-port-write, registered-read parameter memory with a hardware clear sweep.
// After reset, and on every i_clear pulse, the whole array is zeroed one word per
// cycle; while that sweep runs (o_busy = 1) read and write requests are ignored.
// Optional feature macro: MEM_RDW_BYPASS_EN
//   undefined: same-address same-cycle read returns the old contents (read-first)
//   defined  : same-address same-cycle read returns i_wr_data (write-first forwarding)
module param_memory #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_clear,
  output logic              o_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q;

  // Array contents carry no reset so the storage maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_accept;
  logic              rd_accept;
  logic              rd_fwd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Requests only count while the sweep is not running.
  assign wr_accept = (state_q == StIdle) && i_wr_en;
  assign rd_accept = (state_q == StIdle) && i_rd_en;

`ifdef MEM_RDW_BYPASS_EN
  // Forward the incoming write word when it targets the address being read.
  assign rd_fwd = wr_accept && (i_wr_addr == i_rd_addr);
`else
  assign rd_fwd = 1'b0;
`endif

  // Next-state logic: sweep pointer walks 0..DEPTH-1, returning to idle on the last word.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (i_clear) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
      StClear: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LastAddr) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State, sweep pointer and registered busy flag; reset lands in the sweep at address 0.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= (state_d == StClear);
    end
  end

  // Single write port shared between the sweep (writes zero) and user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_wr_addr;
    mem_wdata = i_wr_data;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else begin
      mem_we = wr_accept;
    end
  end

  // Array write port.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port; data holds when no read is accepted, valid is a one-cycle pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= rd_fwd ? i_wr_data : mem[i_rd_addr];
      end
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench for param_memory: a behavioural model (array + remaining-sweep
// counter) is compared against the 8x256 instance every cycle, with directed literal
// checks, and a second 32x16 instance exercised with literal checks.
module tb_param_memory;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, DATA_W = 8, ADDR_W = 8
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clear = 1'b0;
  logic [7:0] wr_addr = '0, rd_addr = '0, wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, busy;

  param_memory #(.DATA_W(8), .ADDR_W(8)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_rd_valid(rd_valid),
    .i_clear   (clear),
    .o_busy    (busy)
  );

  // Second instance, DATA_W = 32, ADDR_W = 4
  logic        rstn2 = 1'b0;
  logic        wr_en2 = 1'b0, rd_en2 = 1'b0, clear2 = 1'b0;
  logic [3:0]  wr_addr2 = '0, rd_addr2 = '0;
  logic [31:0] wr_data2 = '0;
  logic [31:0] rd_data2;
  logic        rd_valid2, busy2;

  param_memory #(.DATA_W(32), .ADDR_W(4)) dut2 (
    .i_clk     (clk),
    .i_rstn    (rstn2),
    .i_wr_en   (wr_en2),
    .i_wr_addr (wr_addr2),
    .i_wr_data (wr_data2),
    .i_rd_en   (rd_en2),
    .i_rd_addr (rd_addr2),
    .o_rd_data (rd_data2),
    .o_rd_valid(rd_valid2),
    .i_clear   (clear2),
    .o_busy    (busy2)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  logic dut2_done = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Behavioural model: words still to be zeroed, array image, expected read outputs.
  logic [7:0] m_mem [DEPTH];
  int         busy_left = DEPTH;
  logic [7:0] exp_data = '0;
  logic       exp_valid = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_left <= DEPTH;
      exp_data  <= '0;
      exp_valid <= 1'b0;
    end else if (busy_left > 0) begin
      m_mem[DEPTH - busy_left] <= '0;
      busy_left <= busy_left - 1;
      exp_valid <= 1'b0;
    end else begin
      exp_valid <= rd_en;
      if (rd_en) begin
`ifdef MEM_RDW_BYPASS_EN
        exp_data <= (wr_en && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr];
`else
        exp_data <= m_mem[rd_addr];
`endif
      end
      if (wr_en) m_mem[wr_addr] <= wr_data;
      if (clear) busy_left <= DEPTH;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'b0, busy}, {63'b0, busy_left != 0});
      check("rd_valid", {63'b0, rd_valid}, {63'b0, exp_valid});
      check("rd_data", {56'b0, rd_data}, {56'b0, exp_data});
    end
  end

  task automatic idle_in();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  // Counts negedges with busy high, starting at a negedge where busy is already high.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
  endtask

  // Main directed + random sequence
  initial begin
    int n;
    logic [7:0] exp52;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_busy", {63'b0, busy}, 64'd1);
    check("reset_data", {56'b0, rd_data}, 64'h0);
    tick();
    rstn = 1'b1;
    count_busy(n);
    check("init_sweep_len", n, 64'd256);

    // Any address reads zero after the sweep
    rd_en = 1'b1; rd_addr = 8'h7F;
    tick();
    idle_in();
    check("post_sweep_valid", {63'b0, rd_valid}, 64'd1);
    check("post_sweep_data", {56'b0, rd_data}, 64'h00);

    // Write then read back, then valid drops while data holds
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    rd_en = 1'b0;
    check("wr_rd_valid", {63'b0, rd_valid}, 64'd1);
    check("wr_rd_data", {56'b0, rd_data}, 64'hA5);
    tick();
    check("hold_valid", {63'b0, rd_valid}, 64'd0);
    check("hold_data", {56'b0, rd_data}, 64'hA5);

    // Same-address read/write in one cycle
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'h11;
    tick();
    wr_data = 8'h3C; rd_en = 1'b1; rd_addr = 8'h20;
    tick();
    idle_in();
`ifdef MEM_RDW_BYPASS_EN
    exp52 = 8'h3C;
`else
    exp52 = 8'h11;
`endif
    check("rdw_same_addr", {56'b0, rd_data}, {56'b0, exp52});

    // Clear pulse, requests during the sweep are ignored
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy", {63'b0, busy}, 64'd1);
    wr_en = 1'b1; wr_addr = 8'h05; wr_data = 8'hFF;
    rd_en = 1'b1; rd_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("busy_no_valid", {63'b0, rd_valid}, 64'd0);
    end
    idle_in();
    count_busy(n);
    check("clear_sweep_done", {63'b0, busy}, 64'd0);
    rd_en = 1'b1; rd_addr = 8'h05;
    tick();
    idle_in();
    check("blocked_write_data", {56'b0, rd_data}, 64'h00);
    check("blocked_write_valid", {63'b0, rd_valid}, 64'd1);

    // Reset mid-sweep: outputs drop immediately, full sweep after release
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    idle_in();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("sweep_holds_data", {56'b0, rd_data}, 64'h5A);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_busy", {63'b0, busy}, 64'd1);
    check("async_rst_data", {56'b0, rd_data}, 64'h00);
    check("async_rst_valid", {63'b0, rd_valid}, 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    count_busy(n);
    check("rst_sweep_len", n, 64'd256);

    // Randomized traffic, biased toward a small address window for collisions
    for (int i = 0; i < 3000; i++) begin
      tick();
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      wr_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 8'($urandom_range(0, 15));
      clear   = ($urandom_range(0, 299) == 0);
    end
    tick();
    idle_in();
    tick();

    wait (dut2_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Second instance: 32-bit words, 16-entry array
  initial begin
    int n;
    tick();
    tick();
    rstn2 = 1'b1;
    n = 0;
    while (busy2 && n < 200) begin
      tick();
      n++;
    end
    check("d2_init_sweep_len", n, 64'd16);
    wr_en2 = 1'b1; wr_addr2 = 4'hF; wr_data2 = 32'hDEADBEEF;
    tick();
    wr_en2 = 1'b0; rd_en2 = 1'b1; rd_addr2 = 4'hF;
    tick();
    rd_en2 = 1'b0;
    check("d2_rd_valid", {63'b0, rd_valid2}, 64'd1);
    check("d2_rd_data", {32'b0, rd_data2}, 64'hDEADBEEF);
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    n = 0;
    while (busy2 && n < 200) begin
      tick();
      n++;
    end
    check("d2_clear_len", n, 64'd16);
    rd_en2 = 1'b1; rd_addr2 = 4'hF;
    tick();
    rd_en2 = 1'b0;
    check("d2_cleared_data", {32'b0, rd_data2}, 64'h0);
    dut2_done = 1'b1;
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 8, address width; depth DEPTH = 2**ADDR_W words (1..12).
REQ-003 i_clk  input  1  single clock, all logic on rising edge.
REQ-004 i_rstn  input  1  asynchronous, active-low reset.
REQ-005 i_wr_en  input  1  write request.
REQ-006 i_wr_addr  input  ADDR_W  write address.
REQ-007 i_wr_data  input  DATA_W  write data.
REQ-008 i_rd_en  input  1  read request.
REQ-009 i_rd_addr  input  ADDR_W  read address.
REQ-010 o_rd_data  output  DATA_W  registered read data.
REQ-011 o_rd_valid  output  1  o_rd_data carries the result of a read accepted the previous cycle.
REQ-012 i_clear  input  1  single-cycle request to zero the whole array.
REQ-013 o_busy  output  1  clear sweep in progress; requests are ignored.

Function
REQ-014 The FSM SHALL have two states, IDLE and CLEAR, plus a clear pointer clr_ptr of ADDR_W bits.
REQ-015 In CLEAR, each cycle SHALL write zero to array[clr_ptr] and increment clr_ptr by one.
REQ-016 In CLEAR with clr_ptr == DEPTH-1, the write SHALL complete and the FSM SHALL move to IDLE on that edge, so a sweep lasts exactly DEPTH cycles.
REQ-017 In IDLE, i_clear = 1 SHALL load clr_ptr = 0 and move to CLEAR on the next edge.
REQ-018 i_clear asserted while in CLEAR SHALL be ignored; the sweep is not restarted.
REQ-019 o_busy SHALL equal (state == CLEAR), driven from a register.
REQ-020 In IDLE, i_wr_en = 1 SHALL write i_wr_data to array[i_wr_addr] on the clock edge.
REQ-021 In IDLE, i_rd_en = 1 SHALL be accepted: o_rd_data SHALL update to array[i_rd_addr] and o_rd_valid SHALL go to 1, both on the next edge (latency 1).
REQ-022 When no read is accepted, o_rd_valid SHALL be 0 and o_rd_data SHALL hold its previous value.
REQ-023 While o_busy = 1, i_wr_en and i_rd_en SHALL have no effect on the array, on o_rd_data or on o_rd_valid (o_rd_valid = 0).
REQ-024 i_wr_en and i_rd_en in the same IDLE cycle to different addresses SHALL both complete independently.
REQ-025 Same-address read and write in the same cycle SHALL follow REQ-040 and REQ-041.
REQ-026 i_clear and i_wr_en/i_rd_en in the same IDLE cycle: the write and read SHALL complete, and the sweep SHALL start on the next cycle.
REQ-027 The array SHALL be inferable as block RAM: no reset on array contents, one write port, one registered read port.

Reset
REQ-028 While i_rstn = 0: o_rd_data = 0, o_rd_valid = 0, o_busy = 1, state = CLEAR, clr_ptr = 0.
REQ-029 After reset release, a full DEPTH-cycle clear sweep SHALL run automatically before any request is accepted.
REQ-030 Reset asserted mid-sweep or mid-read SHALL abort the operation immediately; the sweep restarts from address 0 after release.

Configuration
REQ-040 Without MEM_RDW_BYPASS_EN, a same-address same-cycle read SHALL return the old array contents (read-first).
REQ-041 With MEM_RDW_BYPASS_EN defined, a same-address same-cycle read SHALL return i_wr_data (write-first forwarding); all other behaviour is unchanged.

Verification
REQ-050 Release reset, DATA_W=8, ADDR_W=8 -> o_busy = 1 for exactly 256 cycles, then 0; a read of any address returns 0x00.
REQ-051 Write 0xA5 to address 0x10, then the next cycle read 0x10 -> one cycle later o_rd_valid = 1 and o_rd_data = 0xA5; the cycle after that o_rd_valid = 0 and data holds 0xA5.
REQ-052 Same cycle: write 0x3C to 0x20 and read 0x20 (previously 0x11) -> o_rd_data = 0x11 without the macro, 0x3C with MEM_RDW_BYPASS_EN.
REQ-053 Pulse i_clear, then issue a write of 0xFF to 0x05 and reads during o_busy -> o_rd_valid stays 0; after the sweep, a read of 0x05 returns 0x00.
REQ-054 Assert i_rstn = 0 at sweep cycle 100 -> outputs go to reset values immediately; after release o_busy lasts a full 256 cycles.
REQ-055 ADDR_W=4, DATA_W=32: write 0xDEADBEEF to 0xF, then read 0xF -> returns 0xDEADBEEF; pulse i_clear -> o_busy lasts 16 cycles.
